dffram_fifo: RTL
================

# dffram_fifo

Streaming FIFO controller that drives a single-port dffram instance (one access per cycle, registered read data with 1-cycle latency) as its storage. It accepts a valid/ready write stream, stores entries in the RAM, prefetches them into a 2-entry output buffer, and presents a valid/ready read stream. It is used wherever a pipeline stage needs deep buffering built on the team's single-port RAM rather than on flops.

## Interface
- WIDTH, 32, data width; must match the attached dffram.
- DEPTH, 256, RAM entries; any value ≥ 2, need not be a power of two.
- ADDR_BW (local), $clog2(DEPTH).
- CNT_BW (local), $clog2(DEPTH+3).

- clk_i  in  1  clock; one clock domain; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- wr_data_i  in  WIDTH  write-stream data.
- wr_valid_i  in  1  write-stream valid.
- wr_ready_o  out  1  write-stream ready.
- rd_data_o  out  WIDTH  read-stream data (head of FIFO).
- rd_valid_o  out  1  read-stream valid.
- rd_ready_i  in  1  read-stream ready.
- ram_en_o  out  1  to dffram en_i.
- ram_wr_en_o  out  1  to dffram wr_en_i.
- ram_addr_o  out  ADDR_BW  to dffram addr_i.
- ram_wdata_o  out  WIDTH  to dffram data_i; always equals wr_data_i.
- ram_rdata_i  in  WIDTH  from dffram data_o.
- count_o  out  CNT_BW  total entries held (RAM + in flight + output buffer).

## Operation
- State: wr_ptr, rd_ptr (0..DEPTH-1, wrap DEPTH-1→0), ram_cnt (0..DEPTH), pend flag (read issued last cycle), output buffer of two slots, out (head) and skid, with occ = valid slot count (0..2).
- pop = rd_valid_o & rd_ready_i. rd_valid_o = (occ > 0). rd_data_o = out slot.
- Read issue (combinational): rd_issue = (ram_cnt > 0) & (occ + pend − pop < 2).
- Write accept: wr_ready_o = (ram_cnt < DEPTH) & ~rd_issue; wr_fire = wr_valid_i & wr_ready_o.
- Reads have priority for the single RAM port; writes take every cycle no read is issued.
- RAM port: ram_en_o = rd_issue | wr_fire; ram_wr_en_o = wr_fire; ram_addr_o = rd_issue ? rd_ptr : wr_ptr.
- On rd_issue: rd_ptr advances, ram_cnt−1, pend←1. On wr_fire: wr_ptr advances, ram_cnt+1. Otherwise pend←0.
- When pend=1, ram_rdata_i is captured: into out if out is empty or being popped (after skid shifts to out), else into skid.
- On pop: skid (if valid) shifts to out; occ decrements unless a landing occurs the same cycle.
- count_o = ram_cnt + pend + occ; maximum DEPTH+2.
- Ordering is strict FIFO; no data is dropped or duplicated.

## Timing
- Reset (async assert, sync release): ptrs, ram_cnt, pend, occ = 0; rd_valid_o=0, rd_data_o=0, count_o=0, wr_ready_o=1 only once out of reset (0 while rst_n_i low), ram_en_o=ram_wr_en_o=0 while in reset.
- Write-to-read latency on an empty FIFO: write accepted at edge t, read issued in cycle t+1, rd_valid_o high in cycle t+3.
- Sustained read throughput is 1 entry/cycle while ram_cnt > 0 and the consumer is always ready.
- Read issued in cycle t sees a write committed at edge t−1 or earlier (RAM writes before the following read).
- Full: ram_cnt = DEPTH ⇒ wr_ready_o = 0. Empty: ram_cnt = 0 ⇒ no read issue; rd_valid_o drops once occ = 0.
- Simultaneous wr_valid_i and rd_issue: read wins, wr_ready_o = 0 that cycle.
- rd_valid_o/rd_data_o held stable while rd_ready_i = 0.
- Reset mid-operation discards all contents; RAM contents are not cleared and are never read before rewritten.

## Test plan
- Single entry: after reset, write 0xA5A5A5A5 with rd_ready_i=1 -> ram_wr_en_o at addr 0 in cycle 0, read issue at addr 0 in cycle 1, rd_valid_o with 0xA5A5A5A5 in cycle 3, count_o back to 0.
- Fill: DEPTH=8, rd_ready_i=0, stream writes 0..15 -> 10 accepted (8 RAM + 2 buffer), count_o=10, wr_ready_o=0; then drain yields 0..9 in order.
- Throughput: 8 entries in RAM, rd_ready_i=1 continuously -> 8 consecutive cycles of rd_valid_o with values in order, no bubbles after first data.
- Arbitration: wr_valid_i=1 and rd_ready_i=1 constantly with random data -> no loss, strict order, wr_ready_o never high in a cycle with a read issue.
- Wrap: DEPTH=5, 23 entries pushed/popped with random valid/ready -> pointers wrap at 4→0, scoreboard matches, count_o never exceeds 7.
- Reset mid-stream: assert rst_n_i with 4 entries queued -> rd_valid_o, count_o, ram_en_o immediately 0; after release a new write 0x1 is the first value read.

Source files
------------

// File: rtl/dffram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dffram_fifo
// Brief    : Valid/ready FIFO controller storing entries in a single-port
//            dffram, with a 2-slot prefetch buffer on the read side.
// Revision : 1.0
// ============================================================================
module dffram_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  localparam int ADDR_BW = $clog2(DEPTH),
  localparam int CNT_BW  = $clog2(DEPTH + 3)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic               ram_en_o,
  output logic               ram_wr_en_o,
  output logic [ADDR_BW-1:0] ram_addr_o,
  output logic [WIDTH-1:0]   ram_wdata_o,
  input  logic [WIDTH-1:0]   ram_rdata_i,
  output logic [CNT_BW-1:0]  count_o
);

  localparam logic [ADDR_BW-1:0] c_last_addr = ADDR_BW'(DEPTH - 1);
  localparam logic [CNT_BW-1:0]  c_depth     = CNT_BW'(DEPTH);

  logic [ADDR_BW-1:0] r_wr_ptr;
  logic [ADDR_BW-1:0] r_rd_ptr;
  logic [CNT_BW-1:0]  r_ram_cnt;
  logic               r_pend;
  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_skid;
  logic [1:0]         r_occ;

  logic               w_pop;
  logic               w_rd_issue;
  logic               w_wr_fire;
  logic [2:0]         w_buf_need;

  function automatic logic [ADDR_BW-1:0] f_next(input logic [ADDR_BW-1:0] p);
    return (p == c_last_addr) ? '0 : p + ADDR_BW'(1);
  endfunction

  // A read is only issued when its data is guaranteed a free buffer slot on landing.
  assign w_pop      = (r_occ != 2'd0) & rd_ready_i;
  assign w_buf_need = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_rd_issue = (r_ram_cnt != '0) & (w_buf_need < 3'd2);
  assign wr_ready_o = rst_n_i & (r_ram_cnt < c_depth) & ~w_rd_issue;
  assign w_wr_fire  = wr_valid_i & wr_ready_o;

  assign ram_en_o    = w_rd_issue | w_wr_fire;
  assign ram_wr_en_o = w_wr_fire;
  assign ram_addr_o  = w_rd_issue ? r_rd_ptr : r_wr_ptr;
  assign ram_wdata_o = wr_data_i;

  assign rd_valid_o = (r_occ != 2'd0);
  assign rd_data_o  = r_out;
  assign count_o    = r_ram_cnt + CNT_BW'(r_pend) + CNT_BW'(r_occ);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_pend <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_ptr  <= f_next(r_rd_ptr);
        r_ram_cnt <= r_ram_cnt - CNT_BW'(1);
      end else if (w_wr_fire) begin
        r_wr_ptr  <= f_next(r_wr_ptr);
        r_ram_cnt <= r_ram_cnt + CNT_BW'(1);
      end
    end
  end

  // Landing data goes to the head slot whenever the head is free after this pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out  <= '0;
      r_skid <= '0;
      r_occ  <= 2'd0;
    end else begin
      if (w_pop && (r_occ == 2'd2)) begin
        r_out <= r_skid;
      end
      if (r_pend) begin
        if ((r_occ == 2'd0) || (w_pop && (r_occ == 2'd1))) begin
          r_out <= ram_rdata_i;
        end else begin
          r_skid <= ram_rdata_i;
        end
      end
      r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire
